// File: rtl/fighter_pkg.sv
// Shared fighter definitions: move-sequencer states, phase codes and the frame-count
// defaults the combo detectors are tuned against.
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STARTUP  = 3'd1,
    ACTIVE   = 3'd2,
    RECOVERY = 3'd3,
    COOLDOWN = 3'd4
  } state_e;

  localparam logic [1:0] MOVE_PHASE_STARTUP  = 2'd0;
  localparam logic [1:0] MOVE_PHASE_ACTIVE   = 2'd1;
  localparam logic [1:0] MOVE_PHASE_RECOVERY = 2'd2;
  localparam logic [1:0] MOVE_PHASE_IDLE     = 2'd3;

  localparam int DEF_N_COMBOS        = 4;
  localparam int DEF_STARTUP_FRAMES  = 3;
  localparam int DEF_ACTIVE_FRAMES   = 6;
  localparam int DEF_RECOVERY_FRAMES = 10;
  localparam int DEF_COOLDOWN_FRAMES = 30;
  localparam int DEF_CNT_W           = 8;

  // COOLDOWN and IDLE share one externally visible code.
  function automatic logic [1:0] phase_code(input state_e s);
    case (s)
      STARTUP:  phase_code = MOVE_PHASE_STARTUP;
      ACTIVE:   phase_code = MOVE_PHASE_ACTIVE;
      RECOVERY: phase_code = MOVE_PHASE_RECOVERY;
      default:  phase_code = MOVE_PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Frame-count down-counter reused for every move phase; done marks the clk on which
// the current phase should be left.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load wins over a coincident tick, so the entry clk never counts as a frame.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero-length phase is left on the clk after entry.
  assign done = (cnt_q == '0) || (tick && (cnt_q == CNT_W'(1)));

endmodule

// File: rtl/special_move_scheduler.sv
// Grants one special move at a time from the combo detectors and walks it through
// STARTUP/ACTIVE/RECOVERY/COOLDOWN, driving hitbox, input lockout and detector clear.
module special_move_scheduler
  import fighter_pkg::*;
#(
  parameter int N_COMBOS        = DEF_N_COMBOS,
  parameter int STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
  parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
  parameter int RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int CNT_W           = DEF_CNT_W,
  // Derived; at least one bit so a single-combo build still has a move_id port.
  parameter int ID_W            = (N_COMBOS > 1) ? $clog2(N_COMBOS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic [N_COMBOS-1:0] combo_hit,
  input  logic                hit_stun,
  output logic                move_valid,
  output logic [ID_W-1:0]     move_id,
  output logic [1:0]          move_phase,
  output logic                hitbox_active,
  output logic                input_lock,
  output logic                combo_clear,
  output logic                busy
);

  localparam logic [CNT_W-1:0] STARTUP_LD  = CNT_W'(STARTUP_FRAMES);
  localparam logic [CNT_W-1:0] ACTIVE_LD   = CNT_W'(ACTIVE_FRAMES);
  localparam logic [CNT_W-1:0] RECOVERY_LD = CNT_W'(RECOVERY_FRAMES);
  localparam logic [CNT_W-1:0] COOLDOWN_LD = CNT_W'(COOLDOWN_FRAMES);

  state_e              state_q, state_d;
  logic [N_COMBOS-1:0] combo_hit_q, hit_rise;
  logic [ID_W-1:0]     grant_idx;
  logic                grant;
  logic                timer_load, timer_done;
  logic [CNT_W-1:0]    timer_val;

  logic                move_valid_q, move_valid_d;
  logic [ID_W-1:0]     move_id_q, move_id_d;
  logic [1:0]          move_phase_q, move_phase_d;
  logic                hitbox_active_q, hitbox_active_d;
  logic                input_lock_q, input_lock_d;
  logic                combo_clear_q, combo_clear_d;
  logic                busy_q, busy_d;

  // The edge register tracks every clk in every state, so a level held through a
  // move is already "old" by the time the sequencer returns to IDLE.
  assign hit_rise = combo_hit & ~combo_hit_q;

  always_comb begin
    grant_idx = '0;
    for (int i = N_COMBOS - 1; i >= 0; i--) begin
      if (hit_rise[i]) grant_idx = ID_W'(i);
    end
  end

  assign grant = (state_q == IDLE) && enable && !hit_stun && (|hit_rise);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (frame_tick),
    .done     (timer_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant) state_d = STARTUP;
      STARTUP:  if (hit_stun) state_d = COOLDOWN;
                else if (timer_done) state_d = ACTIVE;
      ACTIVE:   if (hit_stun) state_d = COOLDOWN;
                else if (timer_done) state_d = RECOVERY;
      RECOVERY: if (timer_done) state_d = COOLDOWN;
      COOLDOWN: if (timer_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    timer_load = (state_d != state_q) && (state_d != IDLE);
    case (state_d)
      STARTUP:  timer_val = STARTUP_LD;
      ACTIVE:   timer_val = ACTIVE_LD;
      RECOVERY: timer_val = RECOVERY_LD;
      COOLDOWN: timer_val = COOLDOWN_LD;
      default:  timer_val = '0;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    move_valid_d    = (state_d == STARTUP) || (state_d == ACTIVE) || (state_d == RECOVERY);
    input_lock_d    = move_valid_d;
    hitbox_active_d = (state_d == ACTIVE);
    busy_d          = (state_d != IDLE);
    move_phase_d    = phase_code(state_d);
    combo_clear_d   = grant;
    move_id_d       = grant ? grant_idx : move_id_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      combo_hit_q     <= '0;
      move_valid_q    <= 1'b0;
      move_id_q       <= '0;
      move_phase_q    <= 2'd0;
      hitbox_active_q <= 1'b0;
      input_lock_q    <= 1'b0;
      combo_clear_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      combo_hit_q     <= combo_hit;
      move_valid_q    <= move_valid_d;
      move_id_q       <= move_id_d;
      move_phase_q    <= move_phase_d;
      hitbox_active_q <= hitbox_active_d;
      input_lock_q    <= input_lock_d;
      combo_clear_q   <= combo_clear_d;
      busy_q          <= busy_d;
    end
  end

  assign move_valid    = move_valid_q;
  assign move_id       = move_id_q;
  assign move_phase    = move_phase_q;
  assign hitbox_active = hitbox_active_q;
  assign input_lock    = input_lock_q;
  assign combo_clear   = combo_clear_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_special_move_scheduler.sv
// Directed bench for special_move_scheduler: default build plus a build with zero-length
// STARTUP and RECOVERY phases sharing the same stimulus.
module tb_special_move_scheduler;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic       hit_stun;
  logic [3:0] combo_hit;

  logic       mv, hb, il, cc, bz;
  logic [1:0] mid, mph;
  logic       mv2, hb2, il2, cc2, bz2;
  logic [1:0] mid2, mph2;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int e_id;

  special_move_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .combo_hit(combo_hit), .hit_stun(hit_stun),
    .move_valid(mv), .move_id(mid), .move_phase(mph), .hitbox_active(hb),
    .input_lock(il), .combo_clear(cc), .busy(bz)
  );

  special_move_scheduler #(.STARTUP_FRAMES(0), .RECOVERY_FRAMES(0)) dut2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
    .combo_hit(combo_hit), .hit_stun(hit_stun),
    .move_valid(mv2), .move_id(mid2), .move_phase(mph2), .hitbox_active(hb2),
    .input_lock(il2), .combo_clear(cc2), .busy(bz2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One frame_tick every 4 clks, changed on the falling edge.
  initial begin
    frame_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (frame_tick !== 1'b1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (((bz !== 1'b0) || (bz2 !== 1'b0)) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, bz, 0);
    check({tag, "_busy2"}, bz2, 0);
  endtask

  // Scoreboard: every grant pulse must match the next queued move index.
  always @(negedge clk) begin
    if (!reset && cc === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", cc, 0);
      end else begin
        e_id = exp_q.pop_front();
        check("grant_id", mid, e_id);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; hit_stun = 1'b0; combo_hit = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_valid", mv, 0);
    check("rst_id", mid, 0);
    check("rst_phase", mph, 0);
    check("rst_hitbox", hb, 0);
    check("rst_lock", il, 0);
    check("rst_clear", cc, 0);
    check("rst_busy", bz, 0);
    check("rst_busy2", bz2, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_valid", mv, 0);

    // Single rise on bit 2: full phase timeline.
    @(negedge clk); combo_hit = 4'b0100; exp_q.push_back(2);
    @(posedge clk); #1;
    check("A_valid", mv, 1);
    check("A_id", mid, 2);
    check("A_clear", cc, 1);
    check("A_phase_start", mph, 0);
    check("A_lock", il, 1);
    check("A_hitbox_off", hb, 0);
    wait_ticks(2); #1;
    check("A_clear_pulse", cc, 0);
    check("A_hitbox_pre", hb, 0);
    check("A_phase_pre", mph, 0);
    wait_ticks(1); #1;
    check("A_hitbox_on", hb, 1);
    check("A_phase_active", mph, 1);
    combo_hit = 4'b0000;
    wait_ticks(5); #1;
    check("A_hitbox_last", hb, 1);
    wait_ticks(1); #1;
    check("A_hitbox_end", hb, 0);
    check("A_phase_recov", mph, 2);
    check("A_lock_recov", il, 1);
    wait_ticks(9); #1;
    check("A_lock_late", il, 1);
    wait_ticks(1); #1;
    check("A_lock_end", il, 0);
    check("A_valid_end", mv, 0);
    check("A_phase_cool", mph, 3);
    check("A_busy_cool", bz, 1);
    wait_ticks(29); #1;
    check("A_busy_late", bz, 1);
    wait_ticks(1); #1;
    check("A_busy_end", bz, 0);
    check("A_id_hold", mid, 2);

    // Two rises in the same clk: lowest index wins, held bit 3 never fires later.
    @(negedge clk); combo_hit = 4'b1010; exp_q.push_back(1);
    @(posedge clk); #1;
    check("B_id", mid, 1);
    check("B_clear", cc, 1);
    wait_idle("B_idle");
    repeat (10) @(negedge clk);
    check("B_no_regrant", bz, 0);
    combo_hit = 4'b0000;

    // Abort on the 2nd ACTIVE tick.
    @(negedge clk); combo_hit = 4'b0001; exp_q.push_back(0);
    @(posedge clk); #1;
    check("C_id", mid, 0);
    wait_ticks(3); #1;
    check("C_hitbox_on", hb, 1);
    wait_ticks(1);
    repeat (3) @(posedge clk);
    @(negedge clk); hit_stun = 1'b1;
    @(posedge clk); #1;
    check("C_abort_hitbox", hb, 0);
    check("C_abort_lock", il, 0);
    check("C_abort_phase", mph, 3);
    check("C_abort_valid", mv, 0);
    check("C_abort_busy", bz, 1);
    @(negedge clk); hit_stun = 1'b0; combo_hit = 4'b0010;
    wait_ticks(29); #1;
    check("C_busy_late", bz, 1);
    check("C_id_hold_cool", mid, 0);
    wait_ticks(1); #1;
    check("C_busy_end", bz, 0);
    check("C_id_hold_idle", mid, 0);

    // Rises while disabled or stunned are dropped.
    @(negedge clk); combo_hit = 4'b0000; enable = 1'b0;
    @(negedge clk); combo_hit = 4'b0100;
    repeat (6) @(negedge clk);
    check("D_disabled_busy", bz, 0);
    check("D_disabled_clear", cc, 0);
    combo_hit = 4'b0000; enable = 1'b1;
    @(negedge clk); hit_stun = 1'b1; combo_hit = 4'b0001;
    repeat (6) @(negedge clk);
    check("D_stun_busy", bz, 0);
    combo_hit = 4'b0000; hit_stun = 1'b0;
    repeat (3) @(negedge clk);
    check("D_not_queued", bz, 0);

    // Asynchronous reset mid-ACTIVE, then a fresh grant.
    @(negedge clk); combo_hit = 4'b1000; exp_q.push_back(3);
    @(posedge clk); #1;
    check("E_id", mid, 3);
    wait_ticks(3); #1;
    check("E_hitbox_on", hb, 1);
    #2 reset = 1'b1; combo_hit = 4'b0000;
    #1;
    check("E_rst_valid", mv, 0);
    check("E_rst_id", mid, 0);
    check("E_rst_phase", mph, 0);
    check("E_rst_hitbox", hb, 0);
    check("E_rst_lock", il, 0);
    check("E_rst_busy", bz, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk);
    @(negedge clk); combo_hit = 4'b0100; exp_q.push_back(2);
    @(posedge clk); #1;
    check("E_regrant_valid", mv, 1);
    check("E_regrant_id", mid, 2);
    combo_hit = 4'b0000;
    wait_idle("E_idle");

    // Zero-length STARTUP/RECOVERY build.
    @(negedge clk); combo_hit = 4'b0001; exp_q.push_back(0);
    @(posedge clk); #1;
    check("F_valid", mv2, 1);
    check("F_phase_start", mph2, 0);
    check("F_clear", cc2, 1);
    check("F_id", mid2, 0);
    @(posedge clk); #1;
    check("F_phase_active", mph2, 1);
    check("F_hitbox_on", hb2, 1);
    combo_hit = 4'b0000;
    wait_ticks(5); #1;
    check("F_hitbox_last", hb2, 1);
    wait_ticks(1); #1;
    check("F_hitbox_end", hb2, 0);
    check("F_phase_recov", mph2, 2);
    check("F_lock_recov", il2, 1);
    @(posedge clk); #1;
    check("F_phase_cool", mph2, 3);
    check("F_valid_cool", mv2, 0);
    check("F_busy_cool", bz2, 1);
    wait_idle("F_idle");
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
